// File: rtl/disparity_median3x3.sv
// 3x3 median post-filter for the raster disparity stream from stereo_match.
// Fixed 4-cycle latency, no backpressure, zero output on the two-pixel image border.
`timescale 1ns/1ps
module disparity_median3x3 #(
    parameter  int D    = 64,
    parameter  int M    = 450,
    parameter  int H    = 375,
    localparam int DBIT = $clog2(D)
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_dval,
    input  logic [DBIT-1:0] i_data,
    input  logic            i_bypass,
    output logic            o_dval,
    output logic [DBIT-1:0] o_data
);

    localparam int CW = (M > 1) ? $clog2(M) : 1;
    localparam int RW = (H > 1) ? $clog2(H) : 1;

    function automatic logic [DBIT-1:0] min2(input logic [DBIT-1:0] a, input logic [DBIT-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [DBIT-1:0] max2(input logic [DBIT-1:0] a, input logic [DBIT-1:0] b);
        return (a < b) ? b : a;
    endfunction

    function automatic logic [DBIT-1:0] min3(input logic [DBIT-1:0] a, input logic [DBIT-1:0] b,
                                             input logic [DBIT-1:0] c);
        return min2(min2(a, b), c);
    endfunction

    function automatic logic [DBIT-1:0] max3(input logic [DBIT-1:0] a, input logic [DBIT-1:0] b,
                                             input logic [DBIT-1:0] c);
        return max2(max2(a, b), c);
    endfunction

    function automatic logic [DBIT-1:0] med3(input logic [DBIT-1:0] a, input logic [DBIT-1:0] b,
                                             input logic [DBIT-1:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [DBIT-1:0] lb1 [M];
    logic [DBIT-1:0] lb2 [M];
    logic [DBIT-1:0] rd1;
    logic [DBIT-1:0] rd2;

    // win[0] is row-2, win[2] is the current row; column 2 is the newest pixel
    logic [DBIT-1:0] win [3][3];
    logic [DBIT-1:0] srt [3][3];
    logic [DBIT-1:0] lo3, mid3, hi3, med4;
    logic [DBIT-1:0] c2, c3, c4;
    logic            b1, b2, b3, b4;
    logic            v1, v2, v3, v4;

    assign rd1 = lb1[col];
    assign rd2 = lb2[col];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            col    <= '0;
            row    <= '0;
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
            v4     <= 1'b0;
            o_dval <= 1'b0;
            o_data <= '0;
        end else begin
            v1     <= i_dval;
            v2     <= v1;
            v3     <= v2;
            v4     <= v3;
            o_dval <= v4;
            if (v4)
                o_data <= b4 ? '0 : (i_bypass ? c4 : med4);
            if (i_dval) begin
                if (col == CW'(M - 1)) begin
                    col <= '0;
                    row <= (row == RW'(H - 1)) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Datapath registers carry no reset; the valid chain qualifies them.
    always_ff @(posedge i_clk) begin
        if (i_dval) begin
            lb1[col] <= i_data;
            lb2[col] <= rd1;
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= rd2;
            win[1][2] <= rd1;
            win[2][2] <= i_data;
            b1        <= (row < RW'(2)) || (col < CW'(2));
        end

        for (int r = 0; r < 3; r++) begin
            srt[r][0] <= min3(win[r][0], win[r][1], win[r][2]);
            srt[r][1] <= med3(win[r][0], win[r][1], win[r][2]);
            srt[r][2] <= max3(win[r][0], win[r][1], win[r][2]);
        end
        c2 <= win[1][1];
        b2 <= b1;

        lo3  <= max3(srt[0][0], srt[1][0], srt[2][0]);
        mid3 <= med3(srt[0][1], srt[1][1], srt[2][1]);
        hi3  <= min3(srt[0][2], srt[1][2], srt[2][2]);
        c3   <= c2;
        b3   <= b2;

        med4 <= med3(lo3, mid3, hi3);
        c4   <= c3;
        b4   <= b3;
    end

endmodule

// File: doc/disparity_median3x3.md
Name: disparity_median3x3

Overview:
- Post-filter downstream of stereo_match; consumes its raster-order disparity stream (o_dval/o_data).
- Applies a 3x3 median to remove speckle and LRCC-rejected single-pixel holes.
- Emits one filtered disparity per accepted input at a fixed latency.
- No backpressure, same as the upstream stage.

Parameters:
- D, 64: disparity range; data width DBIT = $clog2(D) (localparam).
- M, 450: image width in pixels (columns per line).
- H, 375: image height in lines per frame.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rstn  input  1  asynchronous active-low reset.
- i_dval  input  1  input pixel valid; sampled on rising edge.
- i_data  input  DBIT  disparity from stereo_match, raster order.
- i_bypass  input  1  1 = pass window centre unfiltered; quasi-static, change only between frames.
- o_dval  output  1  output valid.
- o_data  output  DBIT  filtered disparity.

Behaviour:
- Reset (asynchronous assert, i_rstn=0):
  - o_dval=0, o_data=0.
  - Column counter col=0, row counter row=0.
  - All pipeline valid bits cleared.
  - Line-buffer RAM contents are not reset; they are never used while row<2.
- Reset mid-frame: everything is discarded; the next accepted pixel is (0,0).
- Counters:
  - Advance only on i_dval=1.
  - col wraps M-1 -> 0 and increments row.
  - row wraps H-1 -> 0, which is a new frame.
- Line buffers:
  - Two buffers of M x DBIT, addressed by col.
  - Read-before-write in the same cycle: LB1 supplies row-1 and receives i_data; LB2 supplies row-2 and receives the LB1 read data.
  - Written only on i_dval=1.
- Window:
  - 3x3 shift register holding rows row-2..row and cols col-2..col.
  - Shifts only on i_dval=1.
  - The output corresponds to centre pixel (row-1, col-1); the image is therefore shifted by one line and one column.
- Border rule: if row<2 or col<2 at the accepted input, the output value is 0 (invalid disparity) with o_dval=1. This also prevents wrapped columns from mixing lines.
- Median:
  - Unsigned median of 9 values via a compare-exchange network.
  - Pipelined freely internally, subject to the exact latency below.
  - i_bypass=1 outputs the window centre instead, with the same latency and the same border rule.
- Latency: fixed 4 cycles. An input sampled at edge k gives o_dval=1 and valid o_data after edge k+4.
- Gaps: the pipeline advances every cycle. The o_dval pattern equals the i_dval pattern delayed by exactly 4 cycles, and gaps are preserved.
- When o_dval=0, o_data holds its last value.
- Output count per frame is exactly M*H. No flush is required.
- i_dval with X/unknown data: no special handling.

Test Plan (bench uses M=8, H=4, D=64 unless stated):
- Reset check:
  - Stimulus: i_rstn=0 for 3 cycles, then idle 5 cycles.
  - Required: o_dval=0 and o_data=0 throughout; first o_dval exactly 4 edges after the first accepted i_dval.
- Constant frame:
  - Stimulus: 32 contiguous pixels of value 17.
  - Required: 32 outputs. Output index i (r=i/8, c=i%8) is 17 when r>=2 and c>=2, otherwise 0.
- Impulse rejection:
  - Stimulus: all pixels 10 except 63 at (2,3).
  - Required with i_bypass=0: every non-border output is 10.
  - Required with i_bypass=1: the output at input index of (3,4), i.e. 28, is 63; other non-border outputs are 10.
- Horizontal ramp:
  - Stimulus: pixel = c, for 4 rows.
  - Required: for r>=2, c>=2 the output equals c-1; border outputs are 0.
- Gapped input:
  - Stimulus: the constant-frame data with i_dval pattern 1,0,0,1,1,0 repeating.
  - Required: the same value sequence as the contiguous run; o_dval equals i_dval delayed by 4.
- Frame wrap and reset mid-frame:
  - Stimulus: two back-to-back frames.
  - Required: the first 16 outputs of frame 2 obey the border/zero rule.
  - Stimulus: assert i_rstn=0 after pixel 13 of a frame, then replay the full frame.
  - Required: output identical to a clean single-frame run.
